// File: rtl/occupancy_arbiter.sv
// Two-lane front end for the shared occupancy counter: one pending event per lane,
// round-robin service, capacity/underflow guarding, sticky error flags and LED drive.
module occupancy_arbiter #(
  parameter int CAPACITY = 7,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0,
  input  logic             out0,
  input  logic             in1,
  input  logic             out1,
  input  logic             clr_err,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic [1:0]       grant,
  output logic             reject,
  output logic             drop_err,
  output logic             underflow_err,
  output logic [2:0]       leds
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef struct packed {
    logic valid;
    logic is_in;  // 1 = entry, 0 = exit
  } slot_t;

  slot_t slot0, slot1;
  logic  last1;  // 1 when lane 1 was the most recently served lane

  logic serve0, serve1, served, sel_in;
  logic single0, single1, load0, load1, lost;
  logic at_cap, at_zero;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    serve0  = 1'b0;
    serve1  = 1'b0;
    sel_in  = 1'b0;
    served  = 1'b0;
    single0 = 1'b0;
    single1 = 1'b0;
    load0   = 1'b0;
    load1   = 1'b0;
    lost    = 1'b0;

    serve0  = slot0.valid && (!slot1.valid || last1);
    serve1  = slot1.valid && (!slot0.valid || !last1);
    served  = serve0 || serve1;
    sel_in  = serve0 ? slot0.is_in : slot1.is_in;

    // A slot being served this cycle frees up in time to take a new event.
    single0 = in0 ^ out0;
    single1 = in1 ^ out1;
    load0   = single0 && (!slot0.valid || serve0);
    load1   = single1 && (!slot1.valid || serve1);
    lost    = (in0 && out0) || (in1 && out1)
           || (single0 && slot0.valid && !serve0)
           || (single1 && slot1.valid && !serve1);
  end

  assign at_cap  = (occupancy == CAP);
  assign at_zero = (occupancy == '0);
  assign full    = at_cap;
  assign empty   = at_zero;
  assign leds    = occupancy[2:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0         <= '0;
      slot1         <= '0;
      last1         <= 1'b1;
      occupancy     <= '0;
      grant         <= 2'b00;
      reject        <= 1'b0;
      drop_err      <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (load0)       slot0 <= {1'b1, in0};
      else if (serve0) slot0.valid <= 1'b0;

      if (load1)       slot1 <= {1'b1, in1};
      else if (serve1) slot1.valid <= 1'b0;

      if (serve0)      last1 <= 1'b0;
      else if (serve1) last1 <= 1'b1;

      grant  <= {serve1, serve0};
      reject <= served && sel_in && at_cap;

      if (served) begin
        if (sel_in && !at_cap)       occupancy <= occupancy + 1'b1;
        else if (!sel_in && !at_zero) occupancy <= occupancy - 1'b1;
      end

      // A fresh error outranks a simultaneous clear.
      drop_err      <= lost || (drop_err && !clr_err);
      underflow_err <= (served && !sel_in && at_zero) || (underflow_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_occupancy_arbiter.sv
// Directed bench for occupancy_arbiter: inputs change and outputs are sampled on
// the falling edge, so each check sees the state left by the preceding rising edge.
module tb_occupancy_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0, out0, in1, out1, clr_err;
  logic [2:0] occupancy;
  logic       full, empty, reject, drop_err, underflow_err;
  logic [1:0] grant;
  logic [2:0] leds;

  int n_cmp = 0;
  int n_bad = 0;

  occupancy_arbiter #(.CAPACITY(7), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .in0(in0), .out0(out0), .in1(in1), .out1(out1), .clr_err(clr_err),
    .occupancy(occupancy), .full(full), .empty(empty), .grant(grant),
    .reject(reject), .drop_err(drop_err), .underflow_err(underflow_err), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic i0, input logic o0, input logic i1, input logic o1,
                       input logic clr);
    in0 = i0; out0 = o0; in1 = i1; out1 = o1; clr_err = clr;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    check("rst_occ",   occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full, 0);
    check("rst_grant", grant, 0);
    check("rst_rej",   reject, 0);
    check("rst_drop",  drop_err, 0);
    check("rst_uflow", underflow_err, 0);
    check("rst_leds",  leds, 0);
    reset = 1'b1;

    // Single in0 pulse: grant and count appear two edges later.
    tick(); drive(1, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("single_wait", grant, 2'b00);
    tick();
    check("single_grant", grant, 2'b01);
    check("single_occ",   occupancy, 1);
    check("single_leds",  leds, 3'b001);
    check("single_empty", empty, 0);
    tick();
    check("single_gnt_pulse", grant, 2'b00);

    // Simultaneous entries from reset: lane 0 first, then lane 1; repeat for fairness.
    do_reset();
    tick(); drive(1, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    check("arb1_g0", grant, 2'b01);
    check("arb1_o0", occupancy, 1);
    tick();
    check("arb1_g1", grant, 2'b10);
    check("arb1_o1", occupancy, 2);
    drive(1, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("arb2_idle", grant, 2'b00);
    tick();
    check("arb2_g0", grant, 2'b01);
    check("arb2_o0", occupancy, 3);
    tick();
    check("arb2_g1", grant, 2'b10);
    check("arb2_o1", occupancy, 4);

    // Fill to capacity, then a rejected entry, then one exit.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(); drive(1, 0, 0, 0, 0);
      tick(); drive(0, 0, 0, 0, 0);
      tick();
      check("fill_occ", occupancy, 8'(i + 1));
    end
    check("fill_full", full, 1);
    check("fill_leds", leds, 3'b111);
    drive(0, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    check("rej_pulse", reject, 1);
    check("rej_grant", grant, 2'b10);
    check("rej_occ",   occupancy, 7);
    tick();
    check("rej_clear", reject, 0);
    check("rej_occ2",  occupancy, 7);
    drive(0, 1, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    check("exit_occ",  occupancy, 6);
    check("exit_full", full, 0);

    // Underflow on an exit at zero, clear, and error-beats-clear.
    do_reset();
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    check("uf_occ",   occupancy, 0);
    check("uf_flag",  underflow_err, 1);
    check("uf_grant", grant, 2'b10);
    check("uf_empty", empty, 1);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    check("uf_clr", underflow_err, 0);
    drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    check("uf_beats_clr", underflow_err, 1);

    // Illegal in+out on one lane.
    do_reset();
    tick(); drive(1, 1, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("ill_drop", drop_err, 1);
    check("ill_occ",  occupancy, 0);
    tick();
    check("ill_nogrant", grant, 2'b00);
    check("ill_occ2",    occupancy, 0);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    check("ill_clr", drop_err, 0);

    // Lane 0 served first so lane 1 wins the next tie; a second lane-0 pulse is lost.
    drive(1, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    check("col_pre_occ", occupancy, 1);
    drive(1, 0, 1, 0, 0);
    tick(); drive(1, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("col_grant1", grant, 2'b10);
    check("col_drop",   drop_err, 1);
    check("col_occ1",   occupancy, 2);
    tick();
    check("col_grant0", grant, 2'b01);
    check("col_occ2",   occupancy, 3);
    tick();
    check("col_idle",   grant, 2'b00);
    check("col_occ3",   occupancy, 3);

    // Asynchronous reset with both slots pending, between edges.
    drive(1, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_occ",   occupancy, 0);
    check("mid_empty", empty, 1);
    check("mid_drop",  drop_err, 0);
    check("mid_grant", grant, 2'b00);
    tick(); reset = 1'b1;
    tick();
    check("mid_post_g0", grant, 2'b00);
    tick();
    check("mid_post_g1", grant, 2'b00);
    check("mid_post_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/occupancy_arbiter.md
Name: occupancy_arbiter

Overview:
- Shares the single occupancy counter of the parking/people-counter datapath between two sensor lanes.
- Each lane has its own b1/b2 sequence decoder. The decoder emits one-cycle `in` pulses (sequence 00→10→11→01→00) and `out` pulses (sequence 00→01→11→10→00). Pedestrian sequences produce no pulse.
- This block buffers one event per lane and serves buffered events round-robin, one per cycle.
- It enforces a capacity limit and drives the occupancy, full/empty and LED outputs.

Parameters:
- CAPACITY, 7, maximum occupancy; entries beyond this are rejected.
- CNT_W, 3, occupancy counter width; must satisfy 2^CNT_W > CAPACITY.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in0  input  1  lane 0 entry pulse, one cycle.
- out0  input  1  lane 0 exit pulse, one cycle.
- in1  input  1  lane 1 entry pulse, one cycle.
- out1  input  1  lane 1 exit pulse, one cycle.
- clr_err  input  1  synchronous clear for drop_err and underflow_err.
- occupancy  output  CNT_W  current count.
- full  output  1  high when occupancy == CAPACITY.
- empty  output  1  high when occupancy == 0.
- grant  output  2  one-hot, one-cycle pulse naming the lane served.
- reject  output  1  one-cycle pulse: a served entry was refused because the lot was full.
- drop_err  output  1  sticky: a lane event was lost.
- underflow_err  output  1  sticky: an exit was served at occupancy 0.
- leds  output  3  occupancy[2:0] for the board LEDs.

Behaviour:
- Reset (reset==0, asynchronous):
  - occupancy=0, full=0, empty=1, grant=00, reject=0, drop_err=0, underflow_err=0, leds=000.
  - Both pending slots cleared; round-robin pointer set to "last served = lane 1".
- Per-lane pending slot: a valid bit plus a type bit (1=in, 0=out). Capture rule at each rising edge:
  - Exactly one of inX/outX high:
    - slot empty, or slot served this cycle → load slot.
    - slot full and not served → event discarded; drop_err set.
  - inX and outX both high → illegal; event discarded; drop_err set.
- Arbiter: combinational on slot valid bits; serves at most one slot per cycle.
  - Only one slot valid → serve it.
  - Both valid → serve the lane that is not "last served"; pointer updates to the served lane.
  - No slot valid → pointer holds.
- Service, registered on the edge closing the service cycle:
  - grant[lane]=1 for the following cycle; slot cleared unless reloaded on the same edge.
  - type=in, occupancy<CAPACITY → occupancy+1.
  - type=in, occupancy==CAPACITY → occupancy unchanged; reject=1 for one cycle.
  - type=out, occupancy>0 → occupancy−1.
  - type=out, occupancy==0 → occupancy held at 0 (no wrap); underflow_err set.
- Latency: a pulse sampled at edge E0 is served in the following cycle. Occupancy and grant change at edge E1, 2 edges after the pulse is applied. If the other lane wins arbitration, add 1 cycle.
- full, empty and leds are decoded combinationally from the registered occupancy.
- Sticky flags:
  - clr_err==1 clears both flags at the next edge.
  - A new error in the same cycle as clr_err wins; the flag stays set.
- Throughput: sustained one event per cycle per lane overflows the slots. The decoders guarantee at least 4 cycles between pulses on one lane, so the only losses are back-to-back same-cycle collisions; these are still flagged.
- No counter wrap is allowed at either boundary.

Test Plan:
- Reset then single pulse: release reset, in0 pulse → grant=01 two edges later, occupancy=1, leds=001, empty=0.
- Simultaneous arbitration: in0 and in1 pulsed together from reset → grant=01 then grant=10 on consecutive cycles; occupancy 1 then 2. Repeat → lane 1 is not served first again (fairness); grant order 01,10 follows the pointer.
- Full boundary: issue 7 entries → occupancy=7, full=1. An 8th in1 → reject pulse for 1 cycle, occupancy stays 7. Then out0 → occupancy=6, full=0.
- Underflow: from reset, out1 pulse → occupancy=0, underflow_err=1. clr_err pulse → underflow_err=0.
- Drop and illegal: in0 and out0 in the same cycle → drop_err=1, occupancy unchanged. Separately, lane 0 second pulse while its slot is pending and lane 1 holds the grant → drop_err=1, only one lane-0 event counted.
- Reset mid-operation: both slots pending, reset asserted asynchronously between edges → all outputs return to reset values immediately; no grant follows release.
